zbus_demux_lock: RTL and testbench

ZBUS_DEMUX_LOCK -- requirements
Module: zbus_demux_lock

---
 rtl/zbus_pkg.sv | 12 +
 rtl/zbus_slot.sv | 38 +++
 rtl/zbus_demux_lock.sv | 115 +++++++++++
 tb/tb_zbus_demux_lock.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/zbus_pkg.sv
// Shared zbus constants: default bus geometry and lock-state encoding.
package zbus_pkg;

  localparam int unsigned DefaultBw = 8;
  localparam int unsigned DefaultBn = 4;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } lock_state_e;

endpackage

// File: rtl/zbus_slot.sv
// One-entry output register with valid/ready handshake; accepts a new word in the
// same cycle the held word drains, so a channel sustains one transfer per cycle.
module zbus_slot #(
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_vld_i,
  output logic             in_rdy_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [Width-1:0] out_data_o
);

  logic             vld_q;
  logic [Width-1:0] data_q;
  logic             drain;

  // Masked during reset so nothing is handed downstream in the reset cycle.
  assign out_vld_o  = vld_q & ~rst_i;
  assign drain      = out_vld_o & out_rdy_i;
  assign in_rdy_o   = ~vld_q | drain;
  assign out_data_o = out_vld_o ? data_q : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (in_vld_i && in_rdy_o) begin
      vld_q  <= 1'b1;
      data_q <= in_data_i;
    end else if (drain) begin
      vld_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/zbus_demux_lock.sv
// zbus 1-to-BN demultiplexer with a sticky channel lock; out-of-range targets are
// acknowledged, dropped and flagged on err one cycle later.
module zbus_demux_lock
  import zbus_pkg::*;
#(
  parameter int unsigned BW  = DefaultBw,
  parameter int unsigned BN  = DefaultBn,
  parameter int unsigned BNL = $clog2(BN),
  parameter int unsigned REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            zi_vld,
  input  logic            zi_lck,
  input  logic [BW-1:0]   zi_bus,
  output logic            zi_ack,
  input  logic [BNL-1:0]  zi_sel,
  output logic [BN-1:0]   zo_vld,
  output logic [BN-1:0]   zo_lck,
  output logic [BW*BN-1:0] zo_bus,
  input  logic [BN-1:0]   zo_ack,
  output logic            lock_act,
  output logic [BNL-1:0]  lock_ch,
  output logic            err
);

  lock_state_e    state_q;
  logic [BNL-1:0] lock_ch_q;
  logic           err_q;
  logic [BNL-1:0] tgt;
  logic           tgt_ok;
  logic [BN-1:0]  ch_sel;
  logic           ch_rdy;
  logic           in_xfer;

  assign tgt    = (state_q == StLocked) ? lock_ch_q : zi_sel;
  assign tgt_ok = 32'(tgt) < BN;

  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < int'(BN); i++) begin
      ch_sel[i] = tgt_ok && (tgt == BNL'(i));
    end
  end

  // Invalid targets are swallowed unconditionally so the source never stalls on them.
  assign zi_ack  = tgt_ok ? (zi_vld & ch_rdy) : 1'b1;
  assign in_xfer = zi_vld & zi_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      lock_ch_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= in_xfer & ~tgt_ok;
      unique case (state_q)
        StIdle: begin
          if (in_xfer && zi_lck) begin
            state_q   <= StLocked;
            lock_ch_q <= tgt;
          end
        end
        StLocked: begin
          if (in_xfer && !zi_lck) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lock_act = (state_q == StLocked);
  assign lock_ch  = lock_ch_q;
  assign err      = err_q;

  if (REG != 0) begin : gen_reg
    logic [BN-1:0] slot_rdy;
    logic [BW:0]   slot_out [BN];

    for (genvar i = 0; i < int'(BN); i++) begin : gen_slot
      zbus_slot #(
        .Width(BW + 1)
      ) u_slot (
        .clk_i     (clk),
        .rst_i     (rst),
        .in_vld_i  (zi_vld & ch_sel[i]),
        .in_rdy_o  (slot_rdy[i]),
        .in_data_i ({zi_lck, zi_bus}),
        .out_vld_o (zo_vld[i]),
        .out_rdy_i (zo_ack[i]),
        .out_data_o(slot_out[i])
      );
      assign zo_lck[i]          = slot_out[i][BW];
      assign zo_bus[i*BW +: BW] = slot_out[i][BW-1:0];
    end

    assign ch_rdy = |(slot_rdy & ch_sel);
  end else begin : gen_comb
    always_comb begin
      zo_vld = '0;
      zo_lck = '0;
      zo_bus = '0;
      for (int i = 0; i < int'(BN); i++) begin
        if (ch_sel[i]) begin
          zo_vld[i]          = zi_vld;
          zo_lck[i]          = zi_lck;
          zo_bus[i*BW +: BW] = zi_bus;
        end
      end
    end

    assign ch_rdy = |(zo_ack & ch_sel);
  end

endmodule

// File: tb/tb_zbus_demux_lock.sv
// Randomised and directed bench: BN=4 registered instance against a queue-based model,
// plus directed checks on a BN=3 registered and a BN=4 pass-through instance.
module tb_zbus_demux_lock;

  logic clk;
  logic rst;

  // Main instance: BN=4, REG=1
  logic        m_vld, m_lck, m_ack, m_lact, m_err;
  logic [1:0]  m_sel, m_lch;
  logic [7:0]  m_bus;
  logic [3:0]  m_zovld, m_zolck, m_zoack;
  logic [31:0] m_zobus;

  // BN=3, REG=1
  logic        a_vld, a_lck, a_ack, a_lact, a_err;
  logic [1:0]  a_sel, a_lch;
  logic [7:0]  a_bus;
  logic [2:0]  a_zovld, a_zolck, a_zoack;
  logic [23:0] a_zobus;

  // BN=4, REG=0
  logic        c_vld, c_lck, c_ack, c_lact, c_err;
  logic [1:0]  c_sel, c_lch;
  logic [7:0]  c_bus;
  logic [3:0]  c_zovld, c_zolck, c_zoack;
  logic [31:0] c_zobus;

  zbus_demux_lock #(.BW(8), .BN(4), .REG(1)) u_dut (
    .clk(clk), .rst(rst), .zi_vld(m_vld), .zi_lck(m_lck), .zi_bus(m_bus), .zi_ack(m_ack),
    .zi_sel(m_sel), .zo_vld(m_zovld), .zo_lck(m_zolck), .zo_bus(m_zobus), .zo_ack(m_zoack),
    .lock_act(m_lact), .lock_ch(m_lch), .err(m_err)
  );

  zbus_demux_lock #(.BW(8), .BN(3), .REG(1)) u_dut3 (
    .clk(clk), .rst(rst), .zi_vld(a_vld), .zi_lck(a_lck), .zi_bus(a_bus), .zi_ack(a_ack),
    .zi_sel(a_sel), .zo_vld(a_zovld), .zo_lck(a_zolck), .zo_bus(a_zobus), .zo_ack(a_zoack),
    .lock_act(a_lact), .lock_ch(a_lch), .err(a_err)
  );

  zbus_demux_lock #(.BW(8), .BN(4), .REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .zi_vld(c_vld), .zi_lck(c_lck), .zi_bus(c_bus), .zi_ack(c_ack),
    .zi_sel(c_sel), .zo_vld(c_zovld), .zo_lck(c_zolck), .zo_bus(c_zobus), .zo_ack(c_zoack),
    .lock_act(c_lact), .lock_ch(c_lch), .err(c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: per-channel FIFO of {lck,bus}, at most one entry deep.
  logic [8:0] mq [4][$];
  logic       md_locked;
  int         md_lkch;
  logic       md_err;
  logic       md_known = 1'b0;

  logic        got_ack;
  logic [3:0]  got_vld;
  logic [31:0] got_bus;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // One clock of the main instance: drive, compare against model, advance model.
  task automatic step(input logic rs, input logic vld, input logic lck,
                      input logic [1:0] sel, input logic [7:0] bus, input logic [3:0] zack);
    logic [3:0]  e_vld;
    logic [3:0]  e_lck;
    logic [31:0] e_bus;
    logic        e_ack;
    int          t;
    @(negedge clk);
    rst = rs; m_vld = vld; m_lck = lck; m_sel = sel; m_bus = bus; m_zoack = zack;
    #1;
    t = md_locked ? md_lkch : int'(sel);
    e_vld = '0; e_lck = '0; e_bus = '0;
    for (int i = 0; i < 4; i++) begin
      if (!rs && mq[i].size() != 0) begin
        e_vld[i]       = 1'b1;
        e_lck[i]       = mq[i][0][8];
        e_bus[i*8 +: 8] = mq[i][0][7:0];
      end
    end
    e_ack = vld && (mq[t].size() == 0 || (e_vld[t] && zack[t]));
    got_ack = m_ack; got_vld = m_zovld; got_bus = m_zobus;
    if (md_known) begin
      chk("zi_ack", 32'(m_ack), 32'(e_ack));
      chk("zo_vld", 32'(m_zovld), 32'(e_vld));
      chk("zo_lck", 32'(m_zolck), 32'(e_lck));
      chk("zo_bus", m_zobus, e_bus);
      chk("lock_act", 32'(m_lact), 32'(md_locked));
      chk("lock_ch", 32'(m_lch), 32'(md_lkch));
      chk("err", 32'(m_err), 32'(md_err));
    end
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      md_locked = 1'b0; md_lkch = 0; md_err = 1'b0; md_known = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) if (e_vld[i] && zack[i]) void'(mq[i].pop_front());
      if (vld && e_ack) begin
        mq[t].push_back({lck, bus});
        if (!md_locked && lck) begin
          md_locked = 1'b1; md_lkch = t;
        end else if (md_locked && !lck) begin
          md_locked = 1'b0;
        end
      end
      md_err = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 4'hF);
  endtask

  initial begin
    logic rs, vld;
    rst = 1'b1;
    m_vld = 0; m_lck = 0; m_sel = 0; m_bus = 0; m_zoack = 0;
    a_vld = 0; a_lck = 0; a_sel = 0; a_bus = 0; a_zoack = 3'b111;
    c_vld = 0; c_lck = 0; c_sel = 0; c_bus = 0; c_zoack = 4'hF;

    step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'h0);
    chk("rst_zo_vld", 32'(m_zovld), 32'h0);
    chk("rst_zo_bus", m_zobus, 32'h0);
    chk("rst_lock_act", 32'(m_lact), 32'h0);
    chk("rst_err3", 32'(a_err), 32'h0);

    // Basic routing, one-cycle latency
    step(1'b0, 1'b1, 1'b0, 2'd2, 8'hA5, 4'hF);
    chk("route_ack", 32'(got_ack), 32'h1);
    chk("route_vld", 32'(m_zovld), 32'h4);
    chk("route_bus", 32'(m_zobus[23:16]), 32'hA5);
    idle();
    chk("route_drained", 32'(m_zovld), 32'h0);

    // Lock follows channel 1 even when sel changes
    step(1'b0, 1'b1, 1'b1, 2'd1, 8'h11, 4'hF);
    chk("lock_on_act", 32'(m_lact), 32'h1);
    chk("lock_on_ch", 32'(m_lch), 32'h1);
    chk("lock_on_lck", 32'(m_zolck), 32'h2);
    step(1'b0, 1'b1, 1'b0, 2'd3, 8'h22, 4'hF);
    chk("lock_off_act", 32'(m_lact), 32'h0);
    chk("lock_off_vld", 32'(m_zovld), 32'h2);
    chk("lock_off_bus", 32'(m_zobus[15:8]), 32'h22);
    idle();

    // Backpressure on channel 0
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'h31, 4'hE);
    chk("bp_ack1", 32'(got_ack), 32'h1);
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'h32, 4'hE);
    chk("bp_ack2_stall", 32'(got_ack), 32'h0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'h32, 4'hE);
    chk("bp_ack2_hold", 32'(got_ack), 32'h0);
    chk("bp_hold_bus", 32'(got_bus[7:0]), 32'h31);
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'h32, 4'hF);
    chk("bp_ack2_go", 32'(got_ack), 32'h1);
    chk("bp_first_out", 32'(got_bus[7:0]), 32'h31);
    chk("bp_second_vld", 32'(m_zovld), 32'h1);
    chk("bp_second_bus", 32'(m_zobus[7:0]), 32'h32);
    idle();

    // Reset with slot 1 full and lock held
    step(1'b0, 1'b1, 1'b1, 2'd1, 8'h77, 4'h0);
    chk("pre_rst_vld", 32'(m_zovld), 32'h2);
    chk("pre_rst_lock", 32'(m_lact), 32'h1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'hF);
    chk("rst_cycle_vld", 32'(got_vld), 32'h0);
    chk("post_rst_vld", 32'(m_zovld), 32'h0);
    chk("post_rst_lock", 32'(m_lact), 32'h0);
    idle();

    // BN=3: out-of-range target
    a_vld = 1; a_sel = 2'd3; a_bus = 8'h5A;
    #1;
    chk("bn3_bad_ack", 32'(a_ack), 32'h1);
    idle();
    a_vld = 0;
    chk("bn3_bad_vld", 32'(a_zovld), 32'h0);
    chk("bn3_err_pulse", 32'(a_err), 32'h1);
    idle();
    chk("bn3_err_clear", 32'(a_err), 32'h0);
    a_vld = 1; a_sel = 2'd2; a_bus = 8'hC3;
    idle();
    a_vld = 0;
    chk("bn3_ok_vld", 32'(a_zovld), 32'h4);
    chk("bn3_ok_bus", 32'(a_zobus), 32'hC30000);
    chk("bn3_ok_err", 32'(a_err), 32'h0);

    // REG=0 pass-through
    c_vld = 1; c_sel = 2'd0; c_bus = 8'h5C; c_zoack = 4'hE;
    #1;
    chk("comb_stall_ack", 32'(c_ack), 32'h0);
    chk("comb_vld", 32'(c_zovld), 32'h1);
    chk("comb_bus", c_zobus, 32'h5C);
    c_zoack = 4'hF;
    #1;
    chk("comb_go_ack", 32'(c_ack), 32'h1);
    c_sel = 2'd2; c_lck = 1;
    #1;
    chk("comb_vld2", 32'(c_zovld), 32'h4);
    chk("comb_bus2", c_zobus, 32'h5C0000);
    chk("comb_lck2", 32'(c_zolck), 32'h4);
    idle();
    chk("comb_lock", 32'(c_lact), 32'h1);
    c_sel = 2'd0; c_lck = 0;
    #1;
    chk("comb_locked_route", 32'(c_zovld), 32'h4);
    idle();
    c_vld = 0;
    chk("comb_unlock", 32'(c_lact), 32'h0);

    // Randomised traffic against the model
    for (int n = 0; n < 800; n++) begin
      rs  = ($urandom_range(0, 59) == 0);
      vld = !rs && ($urandom_range(0, 9) < 6);
      step(rs, vld, ($urandom_range(0, 3) == 0), 2'($urandom), 8'($urandom),
           4'($urandom) | 4'($urandom));
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
